// File: rtl/display_capture.sv
// Readback of a multiplexed seven-segment panel: rebuilds four BCD digits
// and the colon dot from the segment/digit-select waveform.
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Segments     panel segment bus, bit0..6 = a..g, bit7 = dp
//   i_Digits       panel digit selects, bit0 = Dig1 .. bit3 = Dig4
//   i_Clear_Error  synchronous clear of o_Error
//   o_Data_Dig1..4 decoded digit: 0-9, 4'hF blank, 4'hE invalid
//   o_Dot          dp captured on Dig2
//   o_Frame_Valid  one-cycle pulse when outputs were refreshed
//   o_Error        sticky: an invalid pattern was accepted
module display_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [7:0] i_Segments,
  input  logic [3:0] i_Digits,
  input  logic       i_Clear_Error,
  output logic [3:0] o_Data_Dig1,
  output logic [3:0] o_Data_Dig2,
  output logic [3:0] o_Data_Dig3,
  output logic [3:0] o_Data_Dig4,
  output logic       o_Dot,
  output logic       o_Frame_Valid,
  output logic       o_Error
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Two-flop synchronizers for the asynchronous panel bus.
  logic [7:0] seg_s1;
  logic [7:0] seg_s2;
  logic [3:0] dig_s1;
  logic [3:0] dig_s2;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= i_Segments;
      seg_s2 <= seg_s1;
      dig_s1 <= i_Digits;
      dig_s2 <= dig_s1;
    end
  end

  // Normalized, active-high view of the panel.
  logic [7:0] seg_n;
  logic [3:0] dig_n;

  assign seg_n = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
  assign dig_n = DIG_ACTIVE_LOW ? ~dig_s2 : dig_s2;

  // Stability filter state.
  logic [7:0]    prev_seg;
  logic [3:0]    prev_dig;
  logic [CW-1:0] cnt;
  logic          done;

  logic          match;
  logic [CW-1:0] cnt_next;
  logic          accept;

  assign match    = (seg_n == prev_seg) && (dig_n == prev_dig);
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Fires on the edge where the run reaches STABLE_CYCLES-1 matches,
  // so a pin value lands 2 + STABLE_CYCLES edges after it appears.
  assign accept = match && !done && (cnt_next == CNT_MAX);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      prev_seg <= '0;
      prev_dig <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      prev_seg <= seg_n;
      prev_dig <= dig_n;
      if (!match) begin
        cnt  <= '0;
        done <= 1'b0;
      end else begin
        cnt <= cnt_next;
        if (accept)
          done <= 1'b1;
      end
    end
  end

  // Digit-select qualification.
  logic       one_hot;
  logic [1:0] idx;

  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (dig_n)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // Segment pattern decode, gfedcba active-high.
  logic [3:0] dec;

  always_comb begin
    dec = 4'hE;
    case (seg_n[6:0])
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      7'h00: dec = 4'hF;
      default: dec = 4'hE;
    endcase
  end

  logic qual;
  logic bad;

  assign qual = accept && one_hot;
  assign bad  = qual && (dec == 4'hE);

  // Shadow capture and frame assembly.
  logic [3:0] shadow [4];
  logic       shadow_dot;
  logic [3:0] mask;
  logic [3:0] data_q [4];
  logic       dot_q;
  logic       fv_q;
  logic       frame_done;

  assign frame_done = (mask == 4'hF);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < 4; i++)
        shadow[i] <= 4'hF;
      shadow_dot <= 1'b0;
    end else if (qual) begin
      shadow[idx] <= dec;
      if (idx == 2'd1)
        shadow_dot <= seg_n[7];
    end
  end

  // A frame completing on the same edge as a new accept copies the old
  // shadows; the new digit only seeds the next frame's mask.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      mask <= '0;
      for (int i = 0; i < 4; i++)
        data_q[i] <= 4'hF;
      dot_q <= 1'b0;
      fv_q  <= 1'b0;
    end else if (frame_done) begin
      for (int i = 0; i < 4; i++)
        data_q[i] <= shadow[i];
      dot_q <= shadow_dot;
      fv_q  <= 1'b1;
      mask  <= qual ? dig_n : 4'b0000;
    end else begin
      fv_q <= 1'b0;
      if (qual)
        mask <= mask | dig_n;
    end
  end

  // Sticky error; a new invalid accept beats a clear.
  logic err_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      err_q <= 1'b0;
    else if (bad)
      err_q <= 1'b1;
    else if (i_Clear_Error)
      err_q <= 1'b0;
  end

  assign o_Data_Dig1   = data_q[0];
  assign o_Data_Dig2   = data_q[1];
  assign o_Data_Dig3   = data_q[2];
  assign o_Data_Dig4   = data_q[3];
  assign o_Dot         = dot_q;
  assign o_Frame_Valid = fv_q;
  assign o_Error       = err_q;

endmodule
